zeros_frame_tx: RTL

- Serial frame generator and transmitter for the zero-counting receiver interface.
- Builds one FRAME_LEN-bit frame of the form leading ones, then a zero run, then trailing ones.
- Shifts the frame out one bit per strobe on data/read.
- Reports the zero count and legality the downstream counter must produce.
- Used as the stimulus source and self-check reference in the cnt-seq lab datapath.

---
 rtl/zeros_frame_tx_pkg.sv | 22 ++
 rtl/zeros_frame_tx_if.sv | 41 ++++
 rtl/zeros_frame_tx_plan.sv | 34 +++
 rtl/zeros_frame_tx.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/zeros_frame_tx_pkg.sv
// Shared types and helpers for the zero-run frame transmitter and its receiver-side checker.
// Used unchanged whether or not ZEROS_TX_ERR_INJECT_EN is defined.
package zeros_pkg;

    localparam int unsigned FRAME_LEN_DEF = 8;
    localparam int unsigned CNT_W_DEF     = 4;

    typedef enum logic [2:0] {
        StIdle,
        StClr,
        StLead,
        StZero,
        StTrail,
        StGapw,
        StFin
    } state_e;

    function automatic int unsigned min_cnt(input int unsigned a, input int unsigned b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/zeros_frame_tx_if.sv
// Frame request / serial output bundle for zeros_frame_tx.
// err_en and err_pos exist only when ZEROS_TX_ERR_INJECT_EN is defined.
interface zeros_frame_tx_if #(
    parameter int unsigned CNT_W = zeros_pkg::CNT_W_DEF
);
    logic             start;
    logic [CNT_W-1:0] lead_in;
    logic [CNT_W-1:0] zeros_in;
`ifdef ZEROS_TX_ERR_INJECT_EN
    logic             err_en;
    logic [CNT_W-1:0] err_pos;
`endif
    logic             rx_clr;
    logic             data;
    logic             read;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] exp_zeros;
    logic             exp_legal;

`ifdef ZEROS_TX_ERR_INJECT_EN
    modport master (
        output start, lead_in, zeros_in, err_en, err_pos,
        input  rx_clr, data, read, busy, done, exp_zeros, exp_legal
    );
    modport slave (
        input  start, lead_in, zeros_in, err_en, err_pos,
        output rx_clr, data, read, busy, done, exp_zeros, exp_legal
    );
`else
    modport master (
        output start, lead_in, zeros_in,
        input  rx_clr, data, read, busy, done, exp_zeros, exp_legal
    );
    modport slave (
        input  start, lead_in, zeros_in,
        output rx_clr, data, read, busy, done, exp_zeros, exp_legal
    );
`endif

endinterface

// File: rtl/zeros_frame_tx_plan.sv
// Combinational frame planner: clips the requested lead/zero lengths to the frame and
// decides whether a requested error position is injectable (ZEROS_TX_ERR_INJECT_EN).
module zeros_frame_plan
    import zeros_pkg::*;
#(
    parameter int unsigned FRAME_LEN = FRAME_LEN_DEF,
    parameter int unsigned CNT_W     = CNT_W_DEF
) (
    input  logic [CNT_W-1:0] i_lead_in,
    input  logic [CNT_W-1:0] i_zeros_in,
    input  logic             i_err_en,
    input  logic [CNT_W-1:0] i_err_pos,
    output logic [CNT_W-1:0] o_eff_lead,
    output logic [CNT_W-1:0] o_eff_zeros,
    output logic             o_inj_ok
);

    int unsigned w_lead;
    int unsigned w_zeros;
    int unsigned w_end;
    int unsigned w_pos;

    always_comb begin
        w_lead  = min_cnt(32'(i_lead_in), FRAME_LEN);
        w_zeros = min_cnt(32'(i_zeros_in), FRAME_LEN - w_lead);
        w_end   = w_lead + w_zeros;
        w_pos   = 32'(i_err_pos);
        // Only a position strictly inside the trailing ones breaks the single zero run.
        o_inj_ok    = i_err_en && (w_zeros != 0) && (w_pos > w_end) && (w_pos < FRAME_LEN);
        o_eff_lead  = CNT_W'(w_lead);
        o_eff_zeros = CNT_W'(w_zeros);
    end

endmodule

// File: rtl/zeros_frame_tx.sv
// Serial frame transmitter: leading ones, a zero run, trailing ones, plus the expected
// receiver result. Optional error injection is enabled by ZEROS_TX_ERR_INJECT_EN.
module zeros_frame_tx
    import zeros_pkg::*;
#(
    parameter int unsigned FRAME_LEN = FRAME_LEN_DEF,
    parameter int unsigned CNT_W     = CNT_W_DEF,
    parameter int unsigned GAP       = 0
) (
    input logic             i_clk,
    input logic             i_reset,
    zeros_frame_tx_if.slave io_bus
);

    localparam int unsigned GAP_W = (GAP > 1) ? $clog2(GAP) : 1;

    logic             w_err_en;
    logic [CNT_W-1:0] w_err_pos;
`ifdef ZEROS_TX_ERR_INJECT_EN
    assign w_err_en  = io_bus.err_en;
    assign w_err_pos = io_bus.err_pos;
`else
    assign w_err_en  = 1'b0;
    assign w_err_pos = '0;
`endif

    logic [CNT_W-1:0] w_eff_lead;
    logic [CNT_W-1:0] w_eff_zeros;
    logic             w_inj_ok;

    zeros_frame_plan #(
        .FRAME_LEN(FRAME_LEN),
        .CNT_W    (CNT_W)
    ) u_plan (
        .i_lead_in  (io_bus.lead_in),
        .i_zeros_in (io_bus.zeros_in),
        .i_err_en   (w_err_en),
        .i_err_pos  (w_err_pos),
        .o_eff_lead (w_eff_lead),
        .o_eff_zeros(w_eff_zeros),
        .o_inj_ok   (w_inj_ok)
    );

    state_e           r_state;
    logic [CNT_W-1:0] r_lead;
    logic [CNT_W-1:0] r_zeros;
    logic [CNT_W-1:0] r_err_pos;
    logic             r_inj;
    logic [CNT_W-1:0] r_bit_cnt;
    logic [GAP_W-1:0] r_gap_cnt;
    logic             r_data;
    logic             r_read;
    logic             r_rx_clr;
    logic             r_busy;
    logic             r_done;
    logic [CNT_W-1:0] r_exp_zeros;
    logic             r_exp_legal;

    // Index, region and value of the bit that goes out on the next emitting edge.
    logic [CNT_W-1:0] w_idx;
    logic [CNT_W-1:0] w_zero_end;
    state_e           w_region;
    logic             w_bit;
    logic             w_last;

    always_comb begin
        w_idx      = (r_state == StClr) ? '0 : r_bit_cnt + 1'b1;
        w_zero_end = r_lead + r_zeros;
        if (w_idx < r_lead) begin
            w_region = StLead;
        end else if (w_idx < w_zero_end) begin
            w_region = StZero;
        end else begin
            w_region = StTrail;
        end
        w_bit  = (w_region != StZero) && !(r_inj && (w_idx == r_err_pos));
        w_last = (r_bit_cnt == CNT_W'(FRAME_LEN - 1));
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state     <= StIdle;
            r_lead      <= '0;
            r_zeros     <= '0;
            r_err_pos   <= '0;
            r_inj       <= 1'b0;
            r_bit_cnt   <= '0;
            r_gap_cnt   <= '0;
            r_data      <= 1'b0;
            r_read      <= 1'b0;
            r_rx_clr    <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_exp_zeros <= '0;
            r_exp_legal <= 1'b1;
        end else begin
            r_read   <= 1'b0;
            r_rx_clr <= 1'b0;
            r_done   <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (io_bus.start) begin
                        r_lead    <= w_eff_lead;
                        r_zeros   <= w_eff_zeros;
                        r_err_pos <= w_err_pos;
                        r_inj     <= w_inj_ok;
                        r_busy    <= 1'b1;
                        r_rx_clr  <= 1'b1;
                        r_state   <= StClr;
                    end
                end
                StClr: begin
                    r_bit_cnt <= w_idx;
                    r_data    <= w_bit;
                    r_read    <= 1'b1;
                    r_state   <= w_region;
                end
                StLead, StZero, StTrail: begin
                    if (w_last) begin
                        r_busy      <= 1'b0;
                        r_done      <= 1'b1;
                        r_exp_zeros <= r_inj ? '0 : r_zeros;
                        r_exp_legal <= !r_inj;
                        r_state     <= StFin;
                    end else if (GAP != 0) begin
                        r_gap_cnt <= '0;
                        r_state   <= StGapw;
                    end else begin
                        r_bit_cnt <= w_idx;
                        r_data    <= w_bit;
                        r_read    <= 1'b1;
                        r_state   <= w_region;
                    end
                end
                StGapw: begin
                    if (r_gap_cnt == GAP_W'(GAP - 1)) begin
                        r_bit_cnt <= w_idx;
                        r_data    <= w_bit;
                        r_read    <= 1'b1;
                        r_state   <= w_region;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + 1'b1;
                    end
                end
                StFin: begin
                    r_state <= StIdle;
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign io_bus.rx_clr    = r_rx_clr;
    assign io_bus.data      = r_data;
    assign io_bus.read      = r_read;
    assign io_bus.busy      = r_busy;
    assign io_bus.done      = r_done;
    assign io_bus.exp_zeros = r_exp_zeros;
    assign io_bus.exp_legal = r_exp_legal;

endmodule
